// File: rtl/alu_if.sv
// Operand/opcode and registered-result bundle between an ALU and its driver.
interface alu_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output a, b, op,
    input  result, carry_out, zero
  );

  modport slave (
    input  a, b, op,
    output result, carry_out, zero
  );
endinterface

// File: rtl/alu.sv
// Registered unsigned ALU: six ops, one-cycle latency, carry/borrow and zero flags.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  logic [WIDTH:0]   wide_c;
  logic [WIDTH-1:0] next_result_c;
  logic             next_carry_c;
  logic             next_zero_c;

  // Reserved or unknown opcodes fall to the default: zero result, no carry.
  always_comb begin
    wide_c        = '0;
    next_result_c = '0;
    next_carry_c  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        wide_c        = {1'b0, bus.a} + {1'b0, bus.b};
        next_result_c = wide_c[WIDTH-1:0];
        next_carry_c  = wide_c[WIDTH];
      end
      OP_SUB: begin
        // Extended-width difference: MSB set exactly when a < b.
        wide_c        = {1'b0, bus.a} - {1'b0, bus.b};
        next_result_c = wide_c[WIDTH-1:0];
        next_carry_c  = wide_c[WIDTH];
      end
      OP_AND:  next_result_c = bus.a & bus.b;
      OP_OR:   next_result_c = bus.a | bus.b;
      OP_XOR:  next_result_c = bus.a ^ bus.b;
      OP_NOT:  next_result_c = ~bus.a;
      default: begin
        next_result_c = '0;
        next_carry_c  = 1'b0;
      end
    endcase
    next_zero_c = (next_result_c == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.result    <= next_result_c;
      bus.carry_out <= next_carry_c;
      bus.zero      <= next_zero_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized check of alu against an integer-arithmetic reference model.
module tb_alu;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {carry, zero, result} straight from the opcode table.
  function automatic logic [W+1:0] model(input logic r, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb, input logic [2:0] mop);
    int unsigned ia;
    int unsigned ib;
    int unsigned res;
    logic        c;
    ia  = int'(ma);
    ib  = int'(mb);
    res = 0;
    c   = 1'b0;
    if (!r) begin
      case (mop)
        3'b000: begin res = (ia + ib) % MOD; c = ((ia + ib) >= MOD); end
        3'b001: begin res = (ia + MOD - ib) % MOD; c = (ia < ib); end
        3'b010: res = int'(ma & mb);
        3'b011: res = int'(ma | mb);
        3'b100: res = int'(ma ^ mb);
        3'b101: res = (MOD - 1) - ia;
        default: res = 0;
      endcase
    end
    return {c, (res == 0), W'(res)};
  endfunction

  task automatic step(input logic r, input logic [W-1:0] sa, input logic [W-1:0] sb,
                      input logic [2:0] sop, input string tag);
    logic [W+1:0] exp;
    @(negedge clk);
    rst    = r;
    bus.a  = sa;
    bus.b  = sb;
    bus.op = sop;
    exp    = model(r, sa, sb, sop);
    @(posedge clk);
    #1;
    compared++;
    assert (bus.result === exp[W-1:0]) else begin
      mismatched++;
      $error("FAIL %s result: got %0h expected %0h", tag, bus.result, exp[W-1:0]);
    end
    compared++;
    assert (bus.carry_out === exp[W+1]) else begin
      mismatched++;
      $error("FAIL %s carry_out: got %b expected %b", tag, bus.carry_out, exp[W+1]);
    end
    compared++;
    assert (bus.zero === exp[W]) else begin
      mismatched++;
      $error("FAIL %s zero: got %b expected %b", tag, bus.zero, exp[W]);
    end
    compared++;
    assert (!$isunknown({bus.result, bus.carry_out, bus.zero})) else begin
      mismatched++;
      $error("FAIL %s xcheck: got %b expected no X/Z", tag,
             {bus.result, bus.carry_out, bus.zero});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.a      = '0;
    bus.b      = '0;
    bus.op     = 3'b000;

    step(1'b1, 4'd5, 4'd3, 3'b000, "reset0");
    step(1'b1, 4'd5, 4'd3, 3'b000, "reset1");
    step(1'b0, 4'd5, 4'd3, 3'b000, "release_add");

    step(1'b0, 4'd15, 4'd1, 3'b000, "add_wrap");
    step(1'b0, 4'd5,  4'd3, 3'b001, "sub_pos");
    step(1'b0, 4'd3,  4'd5, 3'b001, "sub_borrow");
    step(1'b0, 4'd7,  4'd7, 3'b001, "sub_zero");

    step(1'b0, 4'd7, 4'd3, 3'b010, "and");
    step(1'b0, 4'd7, 4'd3, 3'b011, "or");
    step(1'b0, 4'd7, 4'd3, 3'b100, "xor");
    step(1'b0, 4'd5, 4'bxxxx, 3'b101, "not_bx");

    step(1'b0, 4'd9, 4'd6, 3'b110, "rsv110");
    step(1'b0, 4'd9, 4'd6, 3'b111, "rsv111");
    step(1'b0, 4'd9, 4'd6, 3'bxxx, "op_x");

    // Back-to-back opcodes with a one-cycle reset dropped in the middle.
    step(1'b0, 4'd12, 4'd9,  3'b000, "b2b_add");
    step(1'b0, 4'd12, 4'd9,  3'b001, "b2b_sub");
    step(1'b0, 4'd12, 4'd9,  3'b010, "b2b_and");
    step(1'b1, 4'd12, 4'd9,  3'b011, "b2b_rst");
    step(1'b0, 4'd12, 4'd9,  3'b011, "b2b_or");
    step(1'b0, 4'd12, 4'd9,  3'b100, "b2b_xor");
    step(1'b0, 4'd12, 4'd9,  3'b101, "b2b_not");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), W'($urandom), W'($urandom),
           3'($urandom_range(0, 7)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
